// File: rtl/dma_seq_pkg.sv
// Shared constants and types for the DMA descriptor sequencer.
// DMA register map, start codes, FSM encoding and the packed descriptor layout.
package dma_seq_pkg;

   localparam logic [13:0] REG_CTRL = 14'h3FF0;
   localparam logic [13:0] REG_IO   = 14'h3FF1;
   localparam logic [13:0] REG_MEM  = 14'h3FF2;
   localparam logic [13:0] REG_CNT  = 14'h3FF3;

   localparam logic [1:0] START_RD = 2'b01;
   localparam logic [1:0] START_WR = 2'b10;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_PROG_IO  = 3'd1;
   localparam logic [2:0] ST_PROG_MEM = 3'd2;
   localparam logic [2:0] ST_PROG_CNT = 3'd3;
   localparam logic [2:0] ST_START    = 3'd4;
   localparam logic [2:0] ST_WAIT_RUN = 3'd5;
   localparam logic [2:0] ST_WAIT_END = 3'd6;
   localparam logic [2:0] ST_DONE     = 3'd7;

   localparam int unsigned DESC_W = 40;

   typedef struct packed {
      logic        dir;
      logic [13:0] io_adr;
      logic [11:0] mem_adr;
      logic [12:0] cnt;
   } desc_t;

endpackage

// File: rtl/dma_seq_fifo.sv
// DEPTH x 40 descriptor FIFO with show-ahead read data, occupancy level and
// synchronous flush. Pushes when full and pops when empty are ignored.
module dma_seq_fifo
   import dma_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [DESC_W-1:0] wdata,
   output logic [DESC_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       level
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [DESC_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       level_q;
   logic              push_ok, pop_ok;

   assign full    = (level_q == FULL_LVL);
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign push_ok = push & ~full & ~flush;
   assign pop_ok  = pop & ~empty & ~flush;
   assign rdata   = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset; only entries behind the write pointer are ever read.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/dma_seq.sv
// Descriptor sequencer: pops queued descriptors, programs the DMA registers over the
// shared I/O write port (CPU writes win and stall the FSM). Optional IRQ: DMA_SEQ_IRQ_EN.
module dma_seq
   import dma_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rst_pipe,
   input  logic        desc_valid,
   output logic        desc_ready,
   input  logic        desc_dir,
   input  logic [13:0] desc_io_adr,
   input  logic [11:0] desc_mem_adr,
   input  logic [12:0] desc_cnt,
   input  logic        cpu_io_we,
   input  logic [13:0] cpu_io_wadr,
   input  logic [15:0] cpu_io_wdata,
   output logic        dma_io_we,
   output logic [13:0] dma_io_wadr,
   output logic [15:0] dma_io_wdata,
   input  logic [1:0]  dma_status,
   output logic        seq_busy,
   output logic        seq_done,
`ifdef DMA_SEQ_IRQ_EN
   input  logic        seq_irq_clr,
   output logic        seq_irq,
`endif
   output logic [AW:0] q_level
);

   logic [2:0]  state_q, state_d;
   desc_t       desc_q, desc_d, head;
   logic        fifo_full, fifo_empty, pop;
   logic        sq_we;
   logic [13:0] sq_adr;
   logic [15:0] sq_data;

   dma_seq_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (rst_pipe),
      .push  (desc_valid),
      .pop   (pop),
      .wdata ({desc_dir, desc_io_adr, desc_mem_adr, desc_cnt}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (q_level)
   );

   assign desc_ready = ~fifo_full;
   assign seq_busy   = (state_q != ST_IDLE) | ~fifo_empty;
   // DONE is held while the CPU owns the port, so pulse only on the cycle it retires.
   assign seq_done   = (state_q == ST_DONE) & ~cpu_io_we;

   always_comb begin
      state_d = state_q;
      desc_d  = desc_q;
      pop     = 1'b0;
      sq_we   = 1'b0;
      sq_adr  = '0;
      sq_data = '0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && dma_status == 2'b00) begin
               pop     = 1'b1;
               desc_d  = head;
               state_d = (head.cnt == '0) ? ST_DONE : ST_PROG_IO;
            end
         end
         ST_PROG_IO: begin
            sq_we   = 1'b1;
            sq_adr  = REG_IO;
            sq_data = {desc_q.io_adr, 2'b00};
            state_d = ST_PROG_MEM;
         end
         ST_PROG_MEM: begin
            sq_we   = 1'b1;
            sq_adr  = REG_MEM;
            sq_data = {2'b00, desc_q.mem_adr, 2'b00};
            state_d = ST_PROG_CNT;
         end
         ST_PROG_CNT: begin
            sq_we   = 1'b1;
            sq_adr  = REG_CNT;
            sq_data = {3'b000, desc_q.cnt};
            state_d = ST_START;
         end
         ST_START: begin
            sq_we   = 1'b1;
            sq_adr  = REG_CTRL;
            sq_data = {14'h0000, desc_q.dir ? START_WR : START_RD};
            state_d = ST_WAIT_RUN;
         end
         ST_WAIT_RUN: if (dma_status != 2'b00) state_d = ST_WAIT_END;
         ST_WAIT_END: if (dma_status == 2'b00) state_d = ST_DONE;
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase

      if (cpu_io_we) begin
         state_d = state_q;
         desc_d  = desc_q;
         pop     = 1'b0;
      end
      if (rst_pipe) begin
         state_d = ST_IDLE;
         pop     = 1'b0;
      end
   end

   assign dma_io_we    = cpu_io_we | sq_we;
   assign dma_io_wadr  = cpu_io_we ? cpu_io_wadr : sq_adr;
   assign dma_io_wdata = cpu_io_we ? cpu_io_wdata : sq_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         desc_q  <= '0;
      end else begin
         state_q <= state_d;
         desc_q  <= desc_d;
      end
   end

`ifdef DMA_SEQ_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q <= 1'b0;
      end else if (rst_pipe) begin
         irq_q <= 1'b0;
      end else if (seq_done && fifo_empty) begin
         irq_q <= 1'b1;
      end else if (seq_irq_clr) begin
         irq_q <= 1'b0;
      end
   end

   assign seq_irq = irq_q;
`endif

endmodule
